// File: rtl/common_param.sv
// Shared MIPS opcode/funct constants and the memory-stage FSM state type.
package common_param;

   // Primary opcodes (Ins[31:26])
   localparam logic [5:0] OP_R_FORM = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R_FORM funct codes (Ins[5:0])
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // Link register written by JAL
   localparam logic [4:0] REG_RA = 5'd31;

   // Memory-stage FSM states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      HOLD     = 2'd2
   } mem_state_e;

   // True for the two opcodes that touch data memory
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mem_stage_wb_dest_decode.sv
// Destination decode: instruction fields -> writeback register and enable.
// Purely combinational; the caller registers the result.
module wb_dest_decode
   import common_param::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic [4:0] rt_i,
   input  logic [4:0] rd_i,
   output logic [4:0] wb_reg_o,
   output logic       wb_en_o
);

   // Select rd, rt, $ra or nothing depending on instruction class
   always_comb begin
      wb_reg_o = '0;
      wb_en_o  = 1'b0;
      case (op_i)
         OP_R_FORM: begin
            case (funct_i)
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
               FN_JALR, FN_MFHI, FN_MFLO,
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                  wb_reg_o = rd_i;
                  wb_en_o  = 1'b1;
               end
               // JR, MULT/DIV, MTHI/MTLO and unknown funct: no write
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
            wb_reg_o = rt_i;
            wb_en_o  = 1'b1;
         end
         OP_JAL: begin
            wb_reg_o = REG_RA;
            wb_en_o  = 1'b1;
         end
         // SW, branches, J, REGIMM and unknown opcodes: no write
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through, performs aligned LW/SW
// against a req/ack data memory, flags misaligned accesses.
// Optional build macro MEM_TIMEOUT_EN adds an ack timeout of
// TIMEOUT_CYCLES cycles; without it WAIT_ACK waits indefinitely.
module mem_stage
   import common_param::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Ins,
   input  logic [31:0] Result,
   input  logic [31:0] Rdata2,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] WBdata,
   output logic [4:0]  WBreg,
   output logic        WBen,
   output logic        err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   mem_state_e  state_q;
   logic        out_valid_q, err_q, wben_q, is_lw_q;
   logic [31:0] wbdata_q;
   logic [4:0]  wbreg_q;
   logic        dmem_req_q, dmem_we_q;
   logic [31:0] dmem_addr_q, dmem_wdata_q;

   // Decoded view of the incoming instruction
   logic [5:0]  op;
   logic        in_is_lw, in_is_sw, in_is_mem, in_misal;
   logic [4:0]  dec_reg;
   logic        dec_en;
   logic        xfer;
   logic        tmo_hit;

   // Next values loaded on a transfer edge
   mem_state_e  state_d;
   logic        out_valid_d, err_d, wben_d;
   logic [31:0] wbdata_d;
   logic        dmem_req_d, dmem_we_d;
   logic [31:0] dmem_addr_d, dmem_wdata_d;

   // rs and shamt are not needed at this stage
   logic unused_fields;
   assign unused_fields = ^{Ins[25:21], Ins[10:6]};

   assign op        = Ins[31:26];
   assign in_is_lw  = (op == OP_LW);
   assign in_is_sw  = (op == OP_SW);
   assign in_is_mem = is_mem_op(op);
   assign in_misal  = (Result[1:0] != 2'b00);

   wb_dest_decode u_dest (
      .op_i     (op),
      .funct_i  (Ins[5:0]),
      .rt_i     (Ins[20:16]),
      .rd_i     (Ins[15:11]),
      .wb_reg_o (dec_reg),
      .wb_en_o  (dec_en)
   );

   // Ready when empty, or when the held result is leaving this cycle
   assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign xfer     = in_valid && in_ready;

   // Work out where a freshly captured instruction goes
   always_comb begin
      state_d      = HOLD;
      out_valid_d  = 1'b1;
      err_d        = 1'b0;
      wben_d       = dec_en;
      wbdata_d     = Result;
      dmem_req_d   = 1'b0;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = '0;
      dmem_wdata_d = '0;
      if (in_is_mem) begin
         wbdata_d = '0;
         if (in_misal) begin
            err_d  = 1'b1;
            wben_d = 1'b0;
         end else begin
            state_d      = WAIT_ACK;
            out_valid_d  = 1'b0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = in_is_sw;
            dmem_addr_d  = Result;
            dmem_wdata_d = in_is_sw ? Rdata2 : 32'h0;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;

   // Fires on the TIMEOUT_CYCLES-th edge spent in WAIT_ACK without ack
   assign tmo_hit = (state_q == WAIT_ACK) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Cycle counter: runs only in WAIT_ACK, cleared on any exit
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         tmo_q <= '0;
      else if ((state_q == WAIT_ACK) && !dmem_ack && !tmo_hit)
         tmo_q <= tmo_q + TMO_W'(1);
      else
         tmo_q <= '0;
   end
`else
   logic unused_tmo_param;
   assign unused_tmo_param = (TIMEOUT_CYCLES > 0);
   assign tmo_hit = 1'b0;
`endif

   // Stage FSM with registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         wben_q       <= 1'b0;
         wbreg_q      <= '0;
         wbdata_q     <= '0;
         is_lw_q      <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (xfer) begin
                  state_q      <= state_d;
                  out_valid_q  <= out_valid_d;
                  err_q        <= err_d;
                  wben_q       <= wben_d;
                  wbreg_q      <= dec_reg;
                  wbdata_q     <= wbdata_d;
                  is_lw_q      <= in_is_lw;
                  dmem_req_q   <= dmem_req_d;
                  dmem_we_q    <= dmem_we_d;
                  dmem_addr_q  <= dmem_addr_d;
                  dmem_wdata_q <= dmem_wdata_d;
               end else if ((state_q == HOLD) && out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            WAIT_ACK: begin
               // Ack wins over a coincident timeout
               if (dmem_ack) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
                  dmem_req_q  <= 1'b0;
                  dmem_we_q   <= 1'b0;
                  err_q       <= 1'b0;
                  wbdata_q    <= is_lw_q ? dmem_rdata : 32'h0;
               end else if (tmo_hit) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
                  dmem_req_q  <= 1'b0;
                  dmem_we_q   <= 1'b0;
                  err_q       <= 1'b1;
                  wben_q      <= 1'b0;
                  wbdata_q    <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign err        = err_q;
   assign WBen       = wben_q && !err_q;
   assign WBreg      = wbreg_q;
   assign WBdata     = wbdata_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, LW/SW with ack,
// misaligned access, HOLD back-pressure, reset mid-transaction and
// (with MEM_TIMEOUT_EN) the ack timeout.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] Ins = '0, Result = '0, Rdata2 = '0;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid;
   logic [31:0] WBdata;
   logic [4:0]  WBreg;
   logic        WBen, err;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;

   int total = 0;
   int bad   = 0;

   mem_stage #(.TIMEOUT_CYCLES(64)) dut (
      .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .WBdata(WBdata), .WBreg(WBreg), .WBen(WBen), .err(err),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge CLK);
   endtask

   initial begin
      // ---- reset state
      step(); step();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_dmem_req",  {31'b0, dmem_req},  32'd0);
      chk("rst_wben",      {31'b0, WBen},      32'd0);
      chk("rst_err",       {31'b0, err},       32'd0);
      chk("rst_wbdata",    WBdata,             32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      RST = 1'b1;
      step();

      // ---- ADDU $3,$1,$2 -> 1-cycle pass-through
      Ins = 32'h00221821; Result = 32'h7; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("addu_valid",  {31'b0, out_valid}, 32'd1);
      chk("addu_wbdata", WBdata,             32'd7);
      chk("addu_wbreg",  {27'b0, WBreg},     32'd3);
      chk("addu_wben",   {31'b0, WBen},      32'd1);
      chk("addu_err",    {31'b0, err},       32'd0);
      chk("addu_req",    {31'b0, dmem_req},  32'd0);
      step();
      chk("addu_drain",  {31'b0, out_valid}, 32'd0);

      // ---- LW $5,0x100($0), ack three cycles after request
      Ins = 32'h8C050100; Result = 32'h100; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lw_req",      {31'b0, dmem_req},  32'd1);
      chk("lw_we",       {31'b0, dmem_we},   32'd0);
      chk("lw_addr0",    dmem_addr,          32'h100);
      chk("lw_wdata",    dmem_wdata,         32'd0);
      chk("lw_in_ready", {31'b0, in_ready},  32'd0);
      step();
      chk("lw_addr1",    dmem_addr,          32'h100);
      chk("lw_pending",  {31'b0, out_valid}, 32'd0);
      step();
      chk("lw_addr2",    dmem_addr,          32'h100);
      chk("lw_req2",     {31'b0, dmem_req},  32'd1);
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      step();
      chk("lw_valid",    {31'b0, out_valid}, 32'd1);
      chk("lw_wbdata",   WBdata,             32'hDEADBEEF);
      chk("lw_wbreg",    {27'b0, WBreg},     32'd5);
      chk("lw_wben",     {31'b0, WBen},      32'd1);
      chk("lw_req_drop", {31'b0, dmem_req},  32'd0);
      // ack left high into IDLE must be ignored
      step();
      chk("stray_ack_valid", {31'b0, out_valid}, 32'd0);
      chk("stray_ack_req",   {31'b0, dmem_req},  32'd0);
      dmem_ack = 1'b0; dmem_rdata = '0;

      // ---- SW $6,0x204($0)
      Ins = 32'hAC060204; Result = 32'h204; Rdata2 = 32'h12345678; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("sw_req",   {31'b0, dmem_req}, 32'd1);
      chk("sw_we",    {31'b0, dmem_we},  32'd1);
      chk("sw_addr",  dmem_addr,         32'h204);
      chk("sw_wdata", dmem_wdata,        32'h12345678);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      chk("sw_valid",  {31'b0, out_valid}, 32'd1);
      chk("sw_wben",   {31'b0, WBen},      32'd0);
      chk("sw_wbreg",  {27'b0, WBreg},     32'd0);
      chk("sw_wbdata", WBdata,             32'd0);
      step();

      // ---- misaligned LW -> error, no memory request
      Ins = 32'h8C050102; Result = 32'h102; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("mis_valid", {31'b0, out_valid}, 32'd1);
      chk("mis_err",   {31'b0, err},       32'd1);
      chk("mis_wben",  {31'b0, WBen},      32'd0);
      chk("mis_req",   {31'b0, dmem_req},  32'd0);
      step();
      chk("mis_drain_req", {31'b0, dmem_req}, 32'd0);

      // ---- JR $31 -> no writeback
      Ins = 32'h03E00008; Result = 32'h44; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("jr_wben",  {31'b0, WBen},  32'd0);
      chk("jr_wbreg", {27'b0, WBreg}, 32'd0);
      step();

      // ---- ORI $4 held under back-pressure, then JAL back-to-back
      Ins = 32'h34040055; Result = 32'h55; in_valid = 1'b1; out_ready = 1'b0;
      step();
      Ins = 32'h0C000010; Result = 32'h1008;
      for (int i = 0; i < 4; i++) begin
         chk("hold_in_ready", {31'b0, in_ready},  32'd0);
         chk("hold_valid",    {31'b0, out_valid}, 32'd1);
         chk("hold_wbdata",   WBdata,             32'h55);
         chk("hold_wbreg",    {27'b0, WBreg},     32'd4);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("hold_release_ready", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("jal_valid",  {31'b0, out_valid}, 32'd1);
      chk("jal_wbdata", WBdata,             32'h1008);
      chk("jal_wbreg",  {27'b0, WBreg},     32'd31);
      chk("jal_wben",   {31'b0, WBen},      32'd1);
      step();

      // ---- reset while waiting for ack, then a late ack
      Ins = 32'h8C050100; Result = 32'h100; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("rstw_req_before", {31'b0, dmem_req}, 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("rstw_req",   {31'b0, dmem_req},  32'd0);
      chk("rstw_addr",  dmem_addr,          32'd0);
      chk("rstw_valid", {31'b0, out_valid}, 32'd0);
      step();
      RST = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
      step();
      chk("late_ack_valid",  {31'b0, out_valid}, 32'd0);
      chk("late_ack_wbdata", WBdata,             32'd0);
      chk("late_ack_ready",  {31'b0, in_ready},  32'd1);
      dmem_ack = 1'b0;
      step();

`ifdef MEM_TIMEOUT_EN
      // ---- no ack: timeout after 64 cycles in WAIT_ACK
      Ins = 32'h8C050100; Result = 32'h100; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 63; i++) step();
      chk("tmo_req_63",  {31'b0, dmem_req},  32'd1);
      chk("tmo_wait_63", {31'b0, out_valid}, 32'd0);
      step();
      chk("tmo_valid",  {31'b0, out_valid}, 32'd1);
      chk("tmo_err",    {31'b0, err},       32'd1);
      chk("tmo_wben",   {31'b0, WBen},      32'd0);
      chk("tmo_wbdata", WBdata,             32'd0);
      chk("tmo_req",    {31'b0, dmem_req},  32'd0);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
